// File: rtl/numarator_pkg.sv
// Shared constants, operation encoding and helpers for the modulo-N counter family.
package numarator_pkg;

  localparam int WIDTH_DEF  = 6;
  localparam int MODULO_DEF = 60;
  localparam int DIV_DEF    = 1;

  // Per-edge action chosen for the count register (reset is handled separately
  // because it overrides everything in the register process).
  typedef enum logic [2:0] {
    OP_HOLD    = 3'd0,
    OP_LOAD    = 3'd1,
    OP_PAUSE   = 3'd2,
    OP_STEP_UP = 3'd3,
    OP_STEP_DN = 3'd4
  } op_e;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/divizor_tick.sv
// Prescaler: emits a one-cycle tick every DIV enabled clocks.
// clr restarts the phase; en=0 freezes it; reset overrides both.
module divizor_tick
  import numarator_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clk_out_led,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            PW   = clog2_min1(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  generate
    if (DIV < 1) begin : g_bad_div
      $error("divizor_tick: DIV must be >= 1");
    end
  endgenerate

  logic [PW-1:0] pcnt;

  // Tick on the last phase of an enabled, non-cleared, non-reset edge.
  always_comb begin
    tick = 1'b0;
    if (!reset && !clr && en && (pcnt == LAST)) begin
      tick = 1'b1;
    end
  end

  // Phase counter: restart on reset/clear, hold when disabled, wrap on tick.
  always_ff @(posedge clk_out_led) begin
    if (reset || clr) begin
      pcnt <= '0;
    end else if (en) begin
      if (tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

endmodule

// File: rtl/numarator_mod.sv
// Parametrised modulo-N up/down counter with prescaler, parallel load and
// separate one-cycle wrap flags (carry on up-wrap, borrow on down-wrap).
module numarator_mod
  import numarator_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int MODULO = MODULO_DEF,
  parameter int DIV    = DIV_DEF
) (
  input  logic             clk_out_led,
  input  logic             reset,
  input  logic             pause,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] valoare_bin,
  output logic             carry_out,
  output logic             borrow_out
);

  // Top count value and the modulus in one extra bit so MODULO == 2**WIDTH fits.
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULO);

  generate
    if ((MODULO < 2) || (MODULO > (1 << WIDTH))) begin : g_bad_modulo
      $error("numarator_mod: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
    end
    if (DIV < 1) begin : g_bad_div
      $error("numarator_mod: DIV must be >= 1");
    end
  endgenerate

  logic             step;
  logic             run_en;
  op_e              op;
  logic [WIDTH-1:0] val_n;
  logic             carry_n;
  logic             borrow_n;
  logic [WIDTH-1:0] load_sat;

  assign run_en = !pause;

  divizor_tick #(
    .DIV(DIV)
  ) u_div (
    .clk_out_led(clk_out_led),
    .reset      (reset),
    .clr        (load),
    .en         (run_en),
    .tick       (step)
  );

  // Out-of-range load values saturate to the top of the count range.
  always_comb begin
    load_sat = MAX_V;
    if ({1'b0, load_value} < MOD_X) begin
      load_sat = load_value;
    end
  end

  // Select this edge's action: load beats pause, pause beats step.
  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (pause) begin
      op = OP_PAUSE;
    end else if (step) begin
      op = up_down ? OP_STEP_UP : OP_STEP_DN;
    end
  end

  // Next count and flags; flags default low so each pulse lasts one clock.
  always_comb begin
    val_n    = valoare_bin;
    carry_n  = 1'b0;
    borrow_n = 1'b0;
    case (op)
      OP_LOAD: begin
        val_n = load_sat;
      end
      OP_STEP_UP: begin
        if (valoare_bin == MAX_V) begin
          val_n   = '0;
          carry_n = 1'b1;
        end else begin
          val_n = valoare_bin + WIDTH'(1);
        end
      end
      OP_STEP_DN: begin
        if (valoare_bin == '0) begin
          val_n    = MAX_V;
          borrow_n = 1'b1;
        end else begin
          val_n = valoare_bin - WIDTH'(1);
        end
      end
      default: begin
        val_n = valoare_bin;
      end
    endcase
  end

  // Count and flag registers; reset overrides every other input.
  always_ff @(posedge clk_out_led) begin
    if (reset) begin
      valoare_bin <= '0;
      carry_out   <= 1'b0;
      borrow_out  <= 1'b0;
    end else begin
      valoare_bin <= val_n;
      carry_out   <= carry_n;
      borrow_out  <= borrow_n;
    end
  end

endmodule

// File: tb/tb_numarator_mod.sv
// Directed bench for numarator_mod: three instances cover the default
// configuration, a DIV=4 prescaler and the MODULO == 2**WIDTH boundary.
module tb_numarator_mod;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       pause;
  logic       up_down;
  logic       load;
  logic [5:0] load_value;
  logic [3:0] load_value_c;

  logic [5:0] val_a, val_b;
  logic [3:0] val_c;
  logic       carry_a, borrow_a, carry_b, borrow_b, carry_c, borrow_c;

  numarator_mod #(.WIDTH(6), .MODULO(60), .DIV(1)) u_a (
    .clk_out_led(clk), .reset(reset), .pause(pause), .up_down(up_down),
    .load(load), .load_value(load_value),
    .valoare_bin(val_a), .carry_out(carry_a), .borrow_out(borrow_a)
  );

  numarator_mod #(.WIDTH(6), .MODULO(60), .DIV(4)) u_b (
    .clk_out_led(clk), .reset(reset), .pause(pause), .up_down(up_down),
    .load(load), .load_value(load_value),
    .valoare_bin(val_b), .carry_out(carry_b), .borrow_out(borrow_b)
  );

  numarator_mod #(.WIDTH(4), .MODULO(16), .DIV(1)) u_c (
    .clk_out_led(clk), .reset(reset), .pause(pause), .up_down(up_down),
    .load(load), .load_value(load_value_c),
    .valoare_bin(val_c), .carry_out(carry_c), .borrow_out(borrow_c)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  localparam int SEL_A = 0;
  localparam int SEL_B = 1;
  localparam int SEL_C = 2;

  // Pack expected {value, carry, borrow}.
  function automatic logic [7:0] ex(input logic [5:0] v, input logic c, input logic b);
    return {v, c, b};
  endfunction

  // ---------------- driver task ----------------
  // Push the expectation, clock one edge, then pop and compare away from the edge.
  task automatic cyc(input int sel, input string tag, input logic [7:0] e);
    logic [7:0] obs;
    logic [7:0] want;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    case (sel)
      SEL_A:   obs = {val_a, carry_a, borrow_a};
      SEL_B:   obs = {val_b, carry_b, borrow_b};
      default: obs = {2'b00, val_c, carry_c, borrow_c};
    endcase
    want = exp_q.pop_front();
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed val=%0d c=%b b=%b expected val=%0d c=%b b=%b",
             tag, obs[7:2], obs[1], obs[0], want[7:2], want[1], want[0]);
    end
  endtask

  task automatic set_in(input logic r, input logic p, input logic ud,
                        input logic ld, input logic [5:0] lv);
    reset      = r;
    pause      = p;
    up_down    = ud;
    load       = ld;
    load_value = lv;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    load_value_c = 4'd0;
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 6'd0);

    // Default instance: reset for two edges.
    cyc(SEL_A, "a_reset0", ex(6'd0, 1'b0, 1'b0));
    cyc(SEL_A, "a_reset1", ex(6'd0, 1'b0, 1'b0));

    // Count up to 59, then wrap with a one-cycle carry.
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    for (int i = 1; i <= 59; i++) begin
      cyc(SEL_A, "a_up_count", ex(6'(i), 1'b0, 1'b0));
    end
    cyc(SEL_A, "a_up_wrap", ex(6'd0, 1'b1, 1'b0));
    cyc(SEL_A, "a_after_wrap", ex(6'd1, 1'b0, 1'b0));

    // Down wrap straight after reset.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    cyc(SEL_A, "a_reset_dn", ex(6'd0, 1'b0, 1'b0));
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    cyc(SEL_A, "a_dn_wrap", ex(6'd59, 1'b0, 1'b1));
    cyc(SEL_A, "a_dn_58", ex(6'd58, 1'b0, 1'b0));
    // Direction change takes effect on the very next step.
    up_down = 1'b1;
    cyc(SEL_A, "a_dir_up", ex(6'd59, 1'b0, 1'b0));

    // Pause and load.
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
    cyc(SEL_A, "a_reset_pl", ex(6'd0, 1'b0, 1'b0));
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    for (int i = 1; i <= 10; i++) begin
      cyc(SEL_A, "a_to_10", ex(6'(i), 1'b0, 1'b0));
    end
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(SEL_A, "a_pause_hold", ex(6'd10, 1'b0, 1'b0));
    end
    load = 1'b1; load_value = 6'd45;
    cyc(SEL_A, "a_load_paused", ex(6'd45, 1'b0, 1'b0));
    load = 1'b0;
    cyc(SEL_A, "a_load_hold", ex(6'd45, 1'b0, 1'b0));
    cyc(SEL_A, "a_load_hold2", ex(6'd45, 1'b0, 1'b0));
    load = 1'b1; load_value = 6'd63;
    cyc(SEL_A, "a_load_sat", ex(6'd59, 1'b0, 1'b0));
    load = 1'b0; pause = 1'b0;
    cyc(SEL_A, "a_sat_wrap", ex(6'd0, 1'b1, 1'b0));
    // Pause right after a wrap keeps flags low.
    pause = 1'b1; up_down = 1'b0;
    cyc(SEL_A, "a_pause_flag", ex(6'd0, 1'b0, 1'b0));
    pause = 1'b0;
    cyc(SEL_A, "a_dn_wrap2", ex(6'd59, 1'b0, 1'b1));

    // Prescaler DIV=4 phase checks.
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
    cyc(SEL_B, "b_reset", ex(6'd0, 1'b0, 1'b0));
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    cyc(SEL_B, "b_e1", ex(6'd0, 1'b0, 1'b0));
    cyc(SEL_B, "b_e2", ex(6'd0, 1'b0, 1'b0));
    cyc(SEL_B, "b_e3", ex(6'd0, 1'b0, 1'b0));
    cyc(SEL_B, "b_e4", ex(6'd1, 1'b0, 1'b0));
    cyc(SEL_B, "b_e5", ex(6'd1, 1'b0, 1'b0));
    pause = 1'b1;
    cyc(SEL_B, "b_e6_pause", ex(6'd1, 1'b0, 1'b0));
    cyc(SEL_B, "b_e7_pause", ex(6'd1, 1'b0, 1'b0));
    cyc(SEL_B, "b_e8_pause", ex(6'd1, 1'b0, 1'b0));
    pause = 1'b0;
    cyc(SEL_B, "b_e9", ex(6'd1, 1'b0, 1'b0));
    cyc(SEL_B, "b_e10", ex(6'd1, 1'b0, 1'b0));
    cyc(SEL_B, "b_e11", ex(6'd2, 1'b0, 1'b0));
    cyc(SEL_B, "b_e12", ex(6'd2, 1'b0, 1'b0));
    load = 1'b1; load_value = 6'd20;
    cyc(SEL_B, "b_e13_load", ex(6'd20, 1'b0, 1'b0));
    load = 1'b0;
    cyc(SEL_B, "b_e14", ex(6'd20, 1'b0, 1'b0));
    cyc(SEL_B, "b_e15", ex(6'd20, 1'b0, 1'b0));
    cyc(SEL_B, "b_e16", ex(6'd20, 1'b0, 1'b0));
    cyc(SEL_B, "b_e17", ex(6'd21, 1'b0, 1'b0));

    // Reset overrides a simultaneous load and restarts the phase.
    load = 1'b1; load_value = 6'd30;
    cyc(SEL_B, "b_load30", ex(6'd30, 1'b0, 1'b0));
    cyc(SEL_B, "b_e1_after", ex(6'd30, 1'b0, 1'b0));
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 6'd20);
    cyc(SEL_B, "b_reset_load", ex(6'd0, 1'b0, 1'b0));
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    cyc(SEL_B, "b_r1", ex(6'd0, 1'b0, 1'b0));
    cyc(SEL_B, "b_r2", ex(6'd0, 1'b0, 1'b0));
    cyc(SEL_B, "b_r3", ex(6'd0, 1'b0, 1'b0));
    cyc(SEL_B, "b_r4", ex(6'd1, 1'b0, 1'b0));
    // Down count through the prescaler: 1 -> 0 -> wrap to 59.
    up_down = 1'b0;
    for (int i = 0; i < 3; i++) cyc(SEL_B, "b_dn_wait", ex(6'd1, 1'b0, 1'b0));
    cyc(SEL_B, "b_dn_0", ex(6'd0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) cyc(SEL_B, "b_dn_wait2", ex(6'd0, 1'b0, 1'b0));
    cyc(SEL_B, "b_dn_wrap", ex(6'd59, 1'b0, 1'b1));
    cyc(SEL_B, "b_dn_flag_off", ex(6'd59, 1'b0, 1'b0));

    // Boundary MODULO == 2**WIDTH (WIDTH=4, MODULO=16).
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
    cyc(SEL_C, "c_reset", ex(6'd0, 1'b0, 1'b0));
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 6'd0);
    load_value_c = 4'd15;
    cyc(SEL_C, "c_load15", ex(6'd15, 1'b0, 1'b0));
    load = 1'b0;
    cyc(SEL_C, "c_up_wrap", ex(6'd0, 1'b1, 1'b0));
    cyc(SEL_C, "c_after_wrap", ex(6'd1, 1'b0, 1'b0));
    up_down = 1'b0;
    cyc(SEL_C, "c_dn_0", ex(6'd0, 1'b0, 1'b0));
    cyc(SEL_C, "c_dn_wrap", ex(6'd15, 1'b0, 1'b1));
    cyc(SEL_C, "c_dn_14", ex(6'd14, 1'b0, 1'b0));

    // ---------------- final report ----------------
    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain observed %0d left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
